// File: rtl/data_array_pkg.sv
// Shared defaults and FSM encoding for the data-array port controller.
package data_array_pkg;

    localparam int unsigned DA_ADDR_W     = 9;
    localparam int unsigned DA_DATA_W     = 64;
    localparam int unsigned DA_MASK_W     = 8;
    localparam int unsigned DA_RESP_DEPTH = 3;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/data_array_resp_fifo.sv
// Read-response FIFO: circular pointers plus occupancy count, synchronous active-low reset.
module data_array_resp_fifo
    import data_array_pkg::*;
#(
    parameter  int unsigned DEPTH = DA_RESP_DEPTH,
    parameter  int unsigned WIDTH = DA_DATA_W,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             valid_o,
    output logic             full_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pop_ok;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign pop_ok  = pop_i && (cnt_q != '0);
    assign valid_o = (cnt_q != '0);
    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign count_o = cnt_q;
    assign rdata_o = mem_q[rd_q];

    // Pointer and occupancy next-state.
    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (push_i) wr_d = ptr_next(wr_q);
        if (pop_ok) rd_d = ptr_next(rd_q);
        case ({push_i, pop_ok})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Control state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage; contents beyond count are don't-care so no reset.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q] <= wdata_i;
    end

    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n) !(push_i && full_o));

endmodule

// File: rtl/data_array_port_ctrl.sv
// Request-side controller for a single-port RW data-array SRAM: zero sweep, credit-gated accept, response FIFO.
module data_array_port_ctrl
    import data_array_pkg::*;
#(
    parameter int unsigned ADDR_W     = DA_ADDR_W,
    parameter int unsigned DATA_W     = DA_DATA_W,
    parameter int unsigned MASK_W     = DA_MASK_W,
    parameter int unsigned RESP_DEPTH = DA_RESP_DEPTH,
    parameter int unsigned INIT_ZERO  = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [MASK_W-1:0] req_wmask,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              init_done,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_en,
    output logic              sram_wmode,
    output logic [MASK_W-1:0] sram_wmask,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    localparam int unsigned CNT_W = $clog2(RESP_DEPTH + 1);
    localparam int unsigned CRD_W = CNT_W + 1;
    localparam state_e      RST_STATE = (INIT_ZERO != 0) ? ST_INIT : ST_RUN;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ctr_q, ctr_d;
    logic              inflight_q, inflight_d;
    logic              init_done_q, init_done_d;
    logic [CNT_W-1:0]  fifo_count;
    logic [CRD_W-1:0]  credit_used;
    logic              fifo_full;
    logic              resp_pop;

    // Outstanding reads: queued responses plus the one in the SRAM pipeline.
    assign credit_used = CRD_W'(fifo_count) + CRD_W'(inflight_q);
    assign resp_pop    = resp_valid && resp_ready;
    assign init_done   = init_done_q;

    // Next-state and SRAM strobe mux; strobes are gated by reset_n so the macro is idle in reset.
    always_comb begin
        state_d     = state_q;
        ctr_d       = ctr_q;
        inflight_d  = 1'b0;
        init_done_d = init_done_q;
        req_ready   = 1'b0;
        sram_en     = 1'b0;
        sram_wmode  = req_write;
        sram_addr   = req_addr;
        sram_wdata  = req_wdata;
        sram_wmask  = req_wmask;
        case (state_q)
            ST_INIT: begin
                sram_en    = reset_n;
                sram_wmode = 1'b1;
                sram_addr  = ctr_q;
                sram_wdata = '0;
                sram_wmask = '1;
                ctr_d      = ctr_q + ADDR_W'(1);
                if (&ctr_q) begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                end
            end
            ST_RUN: begin
                req_ready  = reset_n && (credit_used < CRD_W'(RESP_DEPTH));
                sram_en    = req_valid && req_ready;
                inflight_d = req_valid && req_ready && !req_write;
            end
            default: state_d = RST_STATE;
        endcase
    end

    // State, sweep counter, in-flight flag and init_done registers.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= RST_STATE;
            ctr_q       <= '0;
            inflight_q  <= 1'b0;
            init_done_q <= (INIT_ZERO == 0);
        end else begin
            state_q     <= state_d;
            ctr_q       <= ctr_d;
            inflight_q  <= inflight_d;
            init_done_q <= init_done_d;
        end
    end

    data_array_resp_fifo #(
        .DEPTH (RESP_DEPTH),
        .WIDTH (DATA_W)
    ) u_resp_fifo (
        .clk     (clock),
        .rst_n   (reset_n),
        .push_i  (inflight_q),
        .wdata_i (sram_rdata),
        .pop_i   (resp_pop),
        .rdata_o (resp_rdata),
        .valid_o (resp_valid),
        .full_o  (fifo_full),
        .count_o (fifo_count)
    );

    a_no_en_in_reset: assert property (@(posedge clock) !reset_n |-> !sram_en);

endmodule

// File: tb/tb_data_array_port_ctrl.sv
// Bench: behavioural SRAM macro with random initial contents, queue-based reference model, directed and random traffic.
module tb_data_array_port_ctrl;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b0;
    logic [8:0]  req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic [7:0]  req_wmask = '0;
    logic        req_ready, resp_valid, init_done, sram_en, sram_wmode;
    logic [63:0] resp_rdata, sram_wdata, sram_rdata;
    logic [8:0]  sram_addr;
    logic [7:0]  sram_wmask;

    always #5 clock = ~clock;

    data_array_port_ctrl dut (
        .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .init_done(init_done),
        .sram_addr(sram_addr), .sram_en(sram_en), .sram_wmode(sram_wmode), .sram_wmask(sram_wmask),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    // Behavioural macro: registered read data, byte-lane masked write, random power-up contents.
    logic [63:0] mac_mem [512];
    logic [63:0] mac_rdata;
    assign sram_rdata = mac_rdata;
    initial begin
        for (int i = 0; i < 512; i++) mac_mem[i] <= {$urandom(), $urandom()};
        mac_rdata <= {$urandom(), $urandom()};
    end
    always @(posedge clock) begin
        if (sram_en) begin
            if (sram_wmode) begin
                for (int l = 0; l < 8; l++)
                    if (sram_wmask[l]) mac_mem[sram_addr][l*8 +: 8] <= sram_wdata[l*8 +: 8];
            end else begin
                mac_rdata <= mac_mem[sram_addr];
            end
        end
    end

    // Reference model state.
    typedef struct { logic [63:0] d; int rdy; } rsp_t;
    rsp_t        mq[$];
    logic [63:0] ref_mem [512];
    bit          m_run = 0, prev_rst = 0, id_seen = 0;
    int          sweep = 0, cyc = 0, rel_cnt = 0, id_cyc = 0;
    int          n_chk = 0, n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // One clock: drive at negedge, check #1 later, advance the model.
    task automatic step(input logic rn, input logic v, input logic w, input logic [8:0] a,
                        input logic [63:0] d, input logic [7:0] m, input logic rr,
                        output logic acc, output logic popped, output logic [63:0] pd);
        bit exp_rv, exp_acc;
        @(negedge clock);
        reset_n = rn; req_valid = v; req_write = w; req_addr = a;
        req_wdata = d; req_wmask = m; resp_ready = rr;
        #1;
        acc = v && req_ready; popped = resp_valid && rr; pd = resp_rdata;
        if (!rn) begin
            chk("rst_req_ready", req_ready, 0);
            chk("rst_sram_en", sram_en, 0);
            if (prev_rst) begin
                chk("rst_resp_valid", resp_valid, 0);
                chk("rst_init_done", init_done, 0);
            end
            mq.delete(); m_run = 0; sweep = 0; rel_cnt = 0; id_seen = 0;
            prev_rst = 1; acc = 0; popped = 0;
        end else begin
            prev_rst = 0;
            rel_cnt++;
            if (init_done === 1'b1 && !id_seen) begin id_seen = 1; id_cyc = rel_cnt; end
            exp_rv = (mq.size() > 0) && (mq[0].rdy <= cyc);
            chk("resp_valid", resp_valid, exp_rv);
            if (exp_rv) chk("resp_rdata", resp_rdata, mq[0].d);
            chk("init_done", init_done, m_run);
            if (!m_run) begin
                chk("init_req_ready", req_ready, 0);
                chk("init_sram_en", sram_en, 1);
                chk("init_wmode", sram_wmode, 1);
                chk("init_addr", sram_addr, sweep);
                chk("init_wmask", sram_wmask, 8'hFF);
                chk("init_wdata", sram_wdata, 0);
                ref_mem[sweep] = '0;
                sweep++;
                if (sweep == 512) m_run = 1;
            end else begin
                exp_acc = v && (mq.size() < 3);
                chk("req_ready", req_ready, mq.size() < 3);
                chk("sram_en", sram_en, exp_acc);
                if (exp_acc) begin
                    chk("sram_wmode", sram_wmode, w);
                    chk("sram_addr", sram_addr, a);
                    if (w) begin
                        chk("sram_wdata", sram_wdata, d);
                        chk("sram_wmask", sram_wmask, m);
                    end
                end
                if (exp_rv && rr) void'(mq.pop_front());
                if (exp_acc && w) begin
                    for (int l = 0; l < 8; l++) if (m[l]) ref_mem[a][l*8 +: 8] = d[l*8 +: 8];
                end else if (exp_acc) begin
                    mq.push_back('{d: ref_mem[a], rdy: cyc + 2});
                end
            end
        end
        cyc++;
    endtask

    task automatic idle(input logic rr, output logic popped, output logic [63:0] pd);
        logic acc;
        step(1, 0, 0, '0, '0, '0, rr, acc, popped, pd);
    endtask

    task automatic do_write(input string nm, input logic [8:0] a, input logic [63:0] d, input logic [7:0] m);
        logic acc = 0, pp; logic [63:0] pd;
        for (int k = 0; k < 10 && !acc; k++) step(1, 1, 1, a, d, m, 1, acc, pp, pd);
        chk({nm, "_accepted"}, acc, 1);
    endtask

    task automatic do_read(input string nm, input logic [8:0] a, input logic [63:0] exp);
        logic acc = 0, pp = 0; logic [63:0] pd = '0;
        int ca = 0, pc = 0;
        for (int k = 0; k < 10 && !acc; k++) begin ca = cyc; step(1, 1, 0, a, '0, '0, 1, acc, pp, pd); end
        chk({nm, "_accepted"}, acc, 1);
        pp = 0;
        for (int k = 0; k < 10 && !pp; k++) begin pc = cyc; idle(1, pp, pd); end
        chk({nm, "_responded"}, pp, 1);
        chk({nm, "_data"}, pd, exp);
        chk({nm, "_latency"}, 64'(pc - ca), 2);
    endtask

    typedef struct { logic w; logic [8:0] a; logic [63:0] d; logic [7:0] m; logic [63:0] exp; } vec_t;
    vec_t tbl [8];

    initial begin
        logic acc, pp; logic [63:0] pd;
        logic [63:0] got [$];
        int nacc, npop;

        tbl[0] = '{0, 9'd300, 64'h0,                 8'h00, 64'h0};
        tbl[1] = '{1, 9'd5,   64'h0123456789ABCDEF,  8'hFF, 64'h0};
        tbl[2] = '{0, 9'd5,   64'h0,                 8'h00, 64'h0123456789ABCDEF};
        tbl[3] = '{1, 9'd5,   64'hFFFFFFFFFFFFFFFF,  8'h0F, 64'h0};
        tbl[4] = '{0, 9'd5,   64'h0,                 8'h00, 64'h01234567FFFFFFFF};
        tbl[5] = '{1, 9'd9,   64'hA5A5A5A5A5A5A5A5,  8'hF0, 64'h0};
        tbl[6] = '{0, 9'd9,   64'h0,                 8'h00, 64'hA5A5A5A500000000};
        tbl[7] = '{1, 9'd7,   64'h1111111111111111,  8'hFF, 64'h0};

        // Reset, then zero sweep.
        for (int i = 0; i < 3; i++) step(0, 0, 0, '0, '0, '0, 0, acc, pp, pd);
        for (int i = 0; i < 513; i++) idle(1, pp, pd);
        chk("init_done_cycle", id_cyc, 513);

        // Directed table.
        for (int i = 0; i < 8; i++) begin
            if (tbl[i].w) do_write($sformatf("tbl%0d", i), tbl[i].a, tbl[i].d, tbl[i].m);
            else          do_read($sformatf("tbl%0d", i), tbl[i].a, tbl[i].exp);
        end

        // Back-to-back reads with the consumer always ready.
        nacc = 0; npop = 0;
        for (int i = 0; i < 16; i++) begin
            step(1, 1, 0, 9'(i), '0, '0, 1, acc, pp, pd);
            nacc += int'(acc); npop += int'(pp);
        end
        for (int i = 0; i < 2; i++) begin idle(1, pp, pd); npop += int'(pp); end
        chk("b2b_accepts", nacc, 16);
        chk("b2b_responses", npop, 16);

        // Backpressure: only three reads fit, then drain in order.
        nacc = 0;
        for (int i = 0; i < 6; i++) begin
            step(1, 1, 0, (i == 0) ? 9'd5 : (i == 1) ? 9'd9 : 9'd7, '0, '0, 0, acc, pp, pd);
            nacc += int'(acc);
        end
        chk("bp_accepts", nacc, 3);
        for (int i = 0; i < 6; i++) begin idle(1, pp, pd); if (pp) got.push_back(pd); end
        chk("bp_drained", got.size(), 3);
        if (got.size() == 3) begin
            chk("bp_data0", got[0], 64'h01234567FFFFFFFF);
            chk("bp_data1", got[1], 64'hA5A5A5A500000000);
            chk("bp_data2", got[2], 64'h1111111111111111);
        end

        // Read then same-row write next cycle returns the old row.
        step(1, 1, 0, 9'd7, '0, '0, 1, acc, pp, pd);
        step(1, 1, 1, 9'd7, 64'h2222222222222222, 8'hFF, 1, acc, pp, pd);
        pp = 0;
        for (int k = 0; k < 6 && !pp; k++) idle(1, pp, pd);
        chk("raw_old_data", pd, 64'h1111111111111111);
        do_read("raw_new", 9'd7, 64'h2222222222222222);

        // Randomized traffic over a small row range to force reuse.
        for (int i = 0; i < 1500; i++)
            step(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 9'($urandom_range(0, 31)),
                 {$urandom(), $urandom()}, 8'($urandom()), 1'($urandom_range(0, 3) != 0), acc, pp, pd);
        for (int i = 0; i < 6; i++) idle(1, pp, pd);

        // Reset with two responses queued: nothing emitted afterwards, sweep restarts.
        step(1, 1, 0, 9'd3, '0, '0, 0, acc, pp, pd);
        step(1, 1, 0, 9'd4, '0, '0, 0, acc, pp, pd);
        idle(0, pp, pd);
        idle(0, pp, pd);
        chk("queued_before_reset", resp_valid, 1);
        for (int i = 0; i < 2; i++) step(0, 0, 0, '0, '0, '0, 1, acc, pp, pd);
        for (int i = 0; i < 513; i++) idle(1, pp, pd);
        chk("reinit_done_cycle", id_cyc, 513);
        do_read("post_reset_row5", 9'd5, 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
